// File: rtl/b2bcd_pkg.sv
// b2bcd_pkg: shared FSM states, seven-segment codes and digit-count check for b2bcd_seg_conv
package b2bcd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  // decimal digits needed for the largest bin_w-bit value, i.e. ceil(bin_w*log10(2))
  function automatic int min_digits(input int bin_w);
    longint unsigned v;
    int d;
    v = (64'd1 << bin_w) - 64'd1;
    d = 0;
    while (v != 64'd0) begin
      d++;
      v = v / 64'd10;
    end
    return d;
  endfunction
endpackage

// File: rtl/b2bcd_seg_conv_if.sv
// b2bcd_seg_conv_if: operand and result valid/ready channels of the BCD/seven-segment converter
interface b2bcd_seg_conv_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [7*DIGITS-1:0]   out_seg;
  logic                  busy;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_seg, busy
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_seg, busy
  );
endinterface

// File: rtl/seg7_enc.sv
// seg7_enc: one BCD nibble to an active-high abcdefg seven-segment code, blank for non-decimal values
module seg7_enc
  import b2bcd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  // lookup of the ten decimal glyphs
  always_comb
    o_seg = i_bcd == 4'd0 ? SEG_0 :
            i_bcd == 4'd1 ? SEG_1 :
            i_bcd == 4'd2 ? SEG_2 :
            i_bcd == 4'd3 ? SEG_3 :
            i_bcd == 4'd4 ? SEG_4 :
            i_bcd == 4'd5 ? SEG_5 :
            i_bcd == 4'd6 ? SEG_6 :
            i_bcd == 4'd7 ? SEG_7 :
            i_bcd == 4'd8 ? SEG_8 :
            i_bcd == 4'd9 ? SEG_9 : SEG_BLANK;
endmodule

// File: rtl/b2bcd_seg_conv.sv
// b2bcd_seg_conv: sequential double-dabble binary-to-BCD with seven-segment outputs; define LZ_BLANK_EN to blank leading zeros
module b2bcd_seg_conv
  import b2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input logic clk,
  input logic rst_n,
  b2bcd_seg_conv_if.slave bus
);
  localparam int SW = 4*DIGITS + BIN_W;
  localparam int CW = $clog2(BIN_W);
  if (DIGITS < min_digits(BIN_W)) begin : g_chk
    $error("DIGITS too small to hold every BIN_W-bit value");
  end
  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_shreg, w_adj, w_shift;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_bcd, w_bcd;
  logic [7*DIGITS-1:0] r_seg, w_seg_raw, w_seg;
  logic [DIGITS-1:0]   w_blank;
  logic                w_load, w_done, w_last, w_in_ready;
  assign w_last        = r_cnt == CW'(BIN_W-1);
  assign w_bcd         = w_shift[SW-1 -: 4*DIGITS];
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_state == DONE;
  assign bus.busy      = r_state == CONV;
  assign bus.out_bcd   = r_bcd;
  assign bus.out_seg   = r_seg;
  // one double-dabble step: +3 on every nibble >= 5, then shift the whole register left
  always_comb begin
    w_adj = r_shreg;
    for (int k = 0; k < DIGITS; k++)
      if (r_shreg[BIN_W+4*k +: 4] >= 4'd5) w_adj[BIN_W+4*k +: 4] = r_shreg[BIN_W+4*k +: 4] + 4'd3;
    w_shift = w_adj << 1;
  end
  for (genvar i = 0; i < DIGITS; i++) begin : g_enc
    seg7_enc u_enc (.i_bcd(w_bcd[4*i +: 4]), .o_seg(w_seg_raw[7*i +: 7]));
  end
`ifdef LZ_BLANK_EN
  // a digit is blanked when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    logic z;
    z = 1'b1;
    w_blank = '0;
    for (int k = DIGITS-1; k > 0; k--) begin
      z = z & (w_bcd[4*k +: 4] == 4'd0);
      w_blank[k] = z;
    end
  end
`else
  assign w_blank = '0;
`endif
  // apply the blanking mask to the raw glyphs
  always_comb begin
    w_seg = w_seg_raw;
    for (int k = 0; k < DIGITS; k++) w_seg[7*k +: 7] = w_blank[k] ? SEG_BLANK : w_seg_raw[7*k +: 7];
  end
  // next state and handshake decode; DONE can hand straight over to CONV when a new operand waits
  always_comb begin
    w_in_ready  = r_state == IDLE || (r_state == DONE && bus.out_ready);
    w_load      = w_in_ready && bus.in_valid;
    w_done      = r_state == CONV && w_last;
    w_state_nxt = r_state;
    if (w_load) w_state_nxt = CONV;
    else if (w_done) w_state_nxt = DONE;
    else if (r_state == DONE && bus.out_ready) w_state_nxt = IDLE;
  end
  // state, shift register, step counter and held result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_seg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_shreg <= {{(4*DIGITS){1'b0}}, bus.in_data};
        r_cnt   <= '0;
      end else if (r_state == CONV) begin
        r_shreg <= w_shift;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_bcd <= w_bcd;
        r_seg <= w_seg;
      end
    end
endmodule
